full_subtractor_reg: RTL and testbench
======================================

Name: full_subtractor_reg

Overview:
- Registered ripple-borrow subtractor computing a − b − bin over WIDTH bits.
- Produces a difference word and a borrow-out.
- WIDTH=1 (default) is the classic 1-bit full subtractor with registered outputs.
- Used as a leaf arithmetic block; b_out chains into the bin of a following stage for wider or multi-word subtraction.

Parameters:
- WIDTH, 1, operand and difference width in bits (legal range 1..64).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operands valid this cycle; result captured at the next clk edge
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- bin  input  1  borrow-in (weight 1, LSB)
- out_valid  output  1  diff/b_out hold a freshly captured result
- diff  output  WIDTH  registered difference
- b_out  output  1  registered borrow-out from the MSB stage

Behaviour:
- One clock (clk); reset is synchronous and active-low (rst_n). It is sampled only on the rising clk edge.
- Reset: while rst_n=0 at a clk edge, diff=0, b_out=0 and out_valid=0. Reset dominates in_valid.
- Per-bit cell i, with borrow chain c0=bin:
  - d_i = a_i ^ b_i ^ c_i
  - c_{i+1} = (~a_i & b_i) | (~(a_i ^ b_i) & c_i)
  - b_out = c_WIDTH
- Arithmetic equivalence: {b_out, diff} = (a − b − bin) mod 2^(WIDTH+1), taken as unsigned.
  - b_out=1 exactly when a < b + bin.
- Latency: exactly 1 cycle. If in_valid=1 at edge N (rst_n=1), then after edge N:
  - diff and b_out reflect the operands sampled at edge N;
  - out_valid=1.
- in_valid=0 at an edge: out_valid goes to 0, and diff/b_out hold their previous values (no update).
- Back-to-back: in_valid=1 on consecutive cycles gives one result per cycle, in order, with out_valid held high.
- There is no backpressure; the consumer must accept a result whenever out_valid=1.
- Boundary cases:
  - a = b with bin=0 → diff=0, b_out=0.
  - a=0, b=0, bin=1 → diff = all ones, b_out=1 (wrap).
  - a = all ones, b=0, bin=0 → diff = all ones, b_out=0.
  - a=0, b = all ones, bin=1 → diff=0, b_out=1.
- Reset asserted mid-stream: the in-flight result is discarded. Outputs are zero at the next edge, and out_valid stays 0 until the first in_valid=1 edge after rst_n returns to 1.
- X/Z on a, b or bin while in_valid=0 must not propagate to the outputs.

Decomposition:
- Package full_subtractor_pkg holds:
  - FS_MAX_WIDTH=64 constant;
  - a reset-value constant (all zeros);
  - a function fs_ref(a, b, bin, width) returning {b_out, diff}, shared with the verification model.
- Sub-module full_subtractor_bit: purely combinational 1-bit cell, with ports a, b, bin → diff, b_out, implementing the per-bit equations above.
  - The top level instantiates it WIDTH times in a generate loop and chains the borrows.
  - The top level registers the outputs and the valid bit.

Test Plan:
- WIDTH=1, all 8 (a,b,bin) vectors, each held one cycle with in_valid=1. Required (diff,b_out) one cycle later:
  - 000→(0,0), 001→(1,1), 010→(1,1), 100→(1,0)
  - 011→(0,1), 101→(0,0), 110→(0,0), 111→(1,1)
- Reset: drive rst_n=0 for 2 edges with in_valid=1, a=1, b=0 → diff=0, b_out=0, out_valid=0. Release; the next in_valid edge gives diff=1, b_out=0, out_valid=1.
- Hold: capture a=1, b=1, bin=1 → (1,1). Then drop in_valid for 3 cycles while toggling a/b → diff=1 and b_out=1 held, out_valid=0.
- WIDTH=8 wrap and limits, one result per cycle back-to-back, out_valid continuously 1:
  - 0x00−0x00−1 → diff=0xFF, b_out=1
  - 0xFF−0x00−0 → 0xFF, 0
  - 0x5A−0x5A−0 → 0x00, 0
  - 0x00−0xFF−1 → 0x00, 1
- Reset mid-stream (WIDTH=8): in_valid=1 with a=0x10, b=0x01 and rst_n=0 at the same edge → outputs zero and out_valid=0. The next valid edge after release yields diff=0x0F, b_out=0.
- Randomized cross-check (WIDTH=1,8,64): 1000 random operands with random in_valid gaps → every out_valid result matches fs_ref on the operands captured one cycle earlier.

Source files
------------

// File: rtl/full_subtractor_pkg.sv
// Shared constants and a behavioural reference for the registered ripple-borrow subtractor.
package full_subtractor_pkg;

    localparam int FS_MAX_WIDTH = 64;
    localparam logic [FS_MAX_WIDTH-1:0] FS_RST_VAL = '0;

    // Result packing: bit FS_MAX_WIDTH is the borrow-out, low bits carry the difference.
    function automatic logic [FS_MAX_WIDTH:0] fs_ref(
        input logic [FS_MAX_WIDTH-1:0] a,
        input logic [FS_MAX_WIDTH-1:0] b,
        input logic                    bin,
        input int unsigned             width
    );
        logic [FS_MAX_WIDTH-1:0] mask;
        logic [FS_MAX_WIDTH:0]   full;
        mask = {FS_MAX_WIDTH{1'b1}} >> (FS_MAX_WIDTH - width);
        full = {1'b0, a & mask} - {1'b0, b & mask} - {{FS_MAX_WIDTH{1'b0}}, bin};
        return {full[FS_MAX_WIDTH], full[FS_MAX_WIDTH-1:0] & mask};
    endfunction

endpackage

// File: rtl/full_subtractor_bit.sv
// 1-bit full subtractor cell: diff = a ^ b ^ bin, borrow when a < b + bin.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs continuously.
module full_subtractor_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic b_out
);

    assign diff  = a ^ b ^ bin;
    assign b_out = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/full_subtractor_reg.sv
// Registered ripple-borrow subtractor: {b_out, diff} = a - b - bin over WIDTH bits.
// Latency: 1 cycle from in_valid to out_valid; outputs hold when in_valid is low.
// Backpressure: none; the consumer must take every result flagged by out_valid.
module full_subtractor_reg
    import full_subtractor_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    output logic [WIDTH-1:0] diff,
    output logic             b_out
);

    logic [WIDTH:0]   borrow;
    logic [WIDTH-1:0] diff_c;

    assign borrow[0] = bin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_subtractor_bit u_bit (
            .a    (a[i]),
            .b    (b[i]),
            .bin  (borrow[i]),
            .diff (diff_c[i]),
            .b_out(borrow[i+1])
        );
    end

    // Data registers load only on in_valid so idle-cycle garbage on a/b/bin never reaches the outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            diff      <= FS_RST_VAL[WIDTH-1:0];
            b_out     <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                diff  <= diff_c;
                b_out <= borrow[WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_full_subtractor_reg.sv
// Self-checking bench for full_subtractor_reg at WIDTH 1, 8 and 64 against an arithmetic model.
module tb_full_subtractor_reg;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        iv1, a1, b1, bin1, ov1, d1, bo1;
    logic        iv8, bin8, ov8, bo8;
    logic [7:0]  a8, b8, d8;
    logic        iv64, bin64, ov64, bo64;
    logic [63:0] a64, b64, d64;

    int n_checks = 0;
    int n_fail   = 0;

    full_subtractor_reg #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .a(a1), .b(b1), .bin(bin1),
        .out_valid(ov1), .diff(d1), .b_out(bo1)
    );
    full_subtractor_reg #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .a(a8), .b(b8), .bin(bin8),
        .out_valid(ov8), .diff(d8), .b_out(bo8)
    );
    full_subtractor_reg #(.WIDTH(64)) u_w64 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv64), .a(a64), .b(b64), .bin(bin64),
        .out_valid(ov64), .diff(d64), .b_out(bo64)
    );

    task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Model: borrow is the unsigned comparison a < b + bin, difference is the wrapped subtraction.
    function automatic logic [64:0] model(input logic [63:0] a, input logic [63:0] b,
                                          input logic bin, input int w);
        logic [63:0] mask;
        logic [64:0] lhs, rhs;
        logic [63:0] d;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        lhs  = {1'b0, a & mask};
        rhs  = {1'b0, b & mask} + 65'(bin);
        d    = (a - b - 64'(bin)) & mask;
        return {lhs < rhs, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [64:0] e1, e8, e64;
    logic        v1, v8, v64;
    logic [7:0]  va [4], vb [4];
    logic        vc [4];
    logic [8:0]  vexp [4];

    initial begin
        rst_n = 1'b0;
        {iv1, a1, b1, bin1} = '0;
        {iv8, a8, b8, bin8} = '0;
        {iv64, a64, b64, bin64} = '0;
        tick();
        tick();
        check("rst_w1",  {ov1, bo1, 63'd0, d1}, 65'd0);
        check("rst_w8",  {ov8, bo8, 56'd0, d8}, 65'd0);
        check("rst_w64_ctl", {63'd0, ov64, bo64}, 65'd0);
        check("rst_w64_diff", 65'(d64), 65'd0);
        rst_n = 1'b1;

        // WIDTH=1 exhaustive truth table
        for (int v = 0; v < 8; v++) begin
            logic [2:0] vv;
            vv = 3'(v);
            iv1 = 1'b1; a1 = vv[2]; b1 = vv[1]; bin1 = vv[0];
            tick();
            check("tt_w1_vld", 65'(ov1), 65'd1);
            check("tt_w1_res", {bo1, 64'(d1)}, model(64'(vv[2]), 64'(vv[1]), vv[0], 1));
        end

        // Reset dominates in_valid
        iv1 = 1'b1; a1 = 1'b1; b1 = 1'b0; bin1 = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_dom_w1", {62'd0, ov1, bo1, d1}, 65'd0);
        rst_n = 1'b1;
        tick();
        check("rst_rel_w1", {62'd0, ov1, bo1, d1}, 65'b101);

        // Hold while in_valid is low
        a1 = 1'b1; b1 = 1'b1; bin1 = 1'b1;
        tick();
        check("hold_cap_w1", {62'd0, ov1, bo1, d1}, 65'b111);
        iv1 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            a1 = ~a1; b1 = (k == 1); bin1 = ~bin1;
            tick();
            check("hold_w1", {62'd0, ov1, bo1, d1}, 65'b011);
        end

        // WIDTH=8 limits, back-to-back
        va = '{8'h00, 8'hFF, 8'h5A, 8'h00};
        vb = '{8'h00, 8'h00, 8'h5A, 8'hFF};
        vc = '{1'b1, 1'b0, 1'b0, 1'b1};
        vexp = '{9'h1FF, 9'h0FF, 9'h000, 9'h100};
        for (int k = 0; k < 4; k++) begin
            iv8 = 1'b1; a8 = va[k]; b8 = vb[k]; bin8 = vc[k];
            tick();
            check("b2b_w8_vld", 65'(ov8), 65'd1);
            check("b2b_w8_res", {bo8, 64'(d8)}, {vexp[k][8], 56'd0, vexp[k][7:0]});
        end

        // Idle inputs must not disturb held outputs
        iv8 = 1'b0; a8 = 8'hA5; b8 = 8'h3C; bin8 = 1'b1;
        tick();
        check("idle_w8", {ov8, bo8, 55'd0, d8}, {2'b01, 55'd0, 8'h00});

        // Reset mid-stream
        iv8 = 1'b1; a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0;
        rst_n = 1'b0;
        tick();
        check("mid_rst_w8", {ov8, bo8, 55'd0, d8}, 65'd0);
        rst_n = 1'b1; iv8 = 1'b0;
        tick();
        check("mid_rst_idle_w8", {ov8, bo8, 55'd0, d8}, 65'd0);
        iv8 = 1'b1;
        tick();
        check("mid_rst_rel_w8", {ov8, bo8, 55'd0, d8}, {2'b10, 55'd0, 8'h0F});

        // Randomized cross-check, all widths in parallel from a clean reset
        rst_n = 1'b0; iv1 = 1'b0; iv8 = 1'b0; iv64 = 1'b0;
        tick();
        rst_n = 1'b1;
        e1 = '0; e8 = '0; e64 = '0; v1 = 1'b0; v8 = 1'b0; v64 = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            iv1  = ($urandom_range(0, 9) < 7);
            iv8  = ($urandom_range(0, 9) < 7);
            iv64 = ($urandom_range(0, 9) < 7);
            a1 = 1'($urandom); b1 = 1'($urandom); bin1 = 1'($urandom);
            a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
            a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom}; bin64 = 1'($urandom);
            if (n % 50 == 0) b64 = a64;
            if (iv1)  e1  = model(64'(a1), 64'(b1), bin1, 1);
            if (iv8)  e8  = model(64'(a8), 64'(b8), bin8, 8);
            if (iv64) e64 = model(a64, b64, bin64, 64);
            v1 = iv1; v8 = iv8; v64 = iv64;
            tick();
            check("rnd_w1_vld",  65'(ov1),  65'(v1));
            check("rnd_w1_res",  {bo1, 64'(d1)}, e1);
            check("rnd_w8_vld",  65'(ov8),  65'(v8));
            check("rnd_w8_res",  {bo8, 64'(d8)}, e8);
            check("rnd_w64_vld", 65'(ov64), 65'(v64));
            check("rnd_w64_res", {bo64, d64}, e64);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
